// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the IF/ID and ID/EXE registers: load-use stall, branch squash, multi-cycle MULT hold.
// Optional STALL_STAT_EN adds a saturating count of cycles with PC_write low.
module pipe_hazard_ctrl #(
  parameter int         MUL_LAT = 4,
  parameter logic [5:0] LW_OP   = 6'h23,
  parameter logic [5:0] SW_OP   = 6'h2B,
  parameter logic [5:0] BEQ_OP  = 6'h04,
  parameter logic [5:0] MULT_FN = 6'h18,
  parameter int         STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        ID_opcode,
  input  logic [4:0]        ID_rs_addr,
  input  logic [4:0]        ID_rt_addr,
  input  logic [5:0]        EXE_opcode,
  input  logic [5:0]        EXE_funct,
  input  logic [4:0]        EXE_rt_addr,
  input  logic              EXE_branch_taken,
  output logic              PC_write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EXE_bubble,
  output logic              EXE_hold,
`ifdef STALL_STAT_EN
  output logic [STAT_W-1:0] stall_cycles,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(MUL_LAT);

  typedef enum logic {RUN, MUL_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mul_in_exe, uses_rt, load_use;

  assign mul_in_exe = (EXE_opcode == 6'h00) && (EXE_funct == MULT_FN);
  assign uses_rt    = (ID_opcode == 6'h00) || (ID_opcode == BEQ_OP) || (ID_opcode == SW_OP);
  assign load_use   = (EXE_opcode == LW_OP) && (EXE_rt_addr != 5'd0) &&
                      ((EXE_rt_addr == ID_rs_addr) || (uses_rt && (EXE_rt_addr == ID_rt_addr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EXE_bubble = 1'b0;
    EXE_hold      = 1'b0;
    busy          = 1'b0;
    // Hold while the MULT occupies EXE; the release cycle (RUN, or MUL_BUSY with cnt==0)
    // evaluates branch and load-use normally and never re-arms on the same MULT.
    if ((state_q == RUN && mul_in_exe) || (state_q == MUL_BUSY && cnt_q != '0)) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      EXE_hold    = 1'b1;
      if (state_q == RUN) begin
        state_d = MUL_BUSY;
        cnt_d   = CNT_W'(MUL_LAT - 2);
      end else begin
        busy  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      state_d = RUN;
      if (EXE_branch_taken) begin
        IF_ID_flush   = 1'b1;
        ID_EXE_bubble = 1'b1;
      end else if (load_use) begin
        PC_write      = 1'b0;
        IF_ID_write   = 1'b0;
        ID_EXE_bubble = 1'b1;
      end
    end
  end

`ifdef STALL_STAT_EN
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!PC_write && (stall_q != {STAT_W{1'b1}})) begin
      stall_q <= stall_q + STAT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a window-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int         MUL_LAT = 4;
  localparam logic [5:0] LW_OP   = 6'h23;
  localparam logic [5:0] SW_OP   = 6'h2B;
  localparam logic [5:0] BEQ_OP  = 6'h04;
  localparam logic [5:0] MULT_FN = 6'h18;
  localparam int         STAT_W  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] ID_opcode, EXE_opcode, EXE_funct;
  logic [4:0] ID_rs_addr, ID_rt_addr, EXE_rt_addr;
  logic       EXE_branch_taken;
  logic       PC_write, IF_ID_write, IF_ID_flush, ID_EXE_bubble, EXE_hold, busy;
`ifdef STALL_STAT_EN
  logic [STAT_W-1:0] stall_cycles;
`endif

  logic [5:0] outs;
  assign outs = {PC_write, IF_ID_write, IF_ID_flush, ID_EXE_bubble, EXE_hold, busy};

  pipe_hazard_ctrl #(
    .MUL_LAT(MUL_LAT), .LW_OP(LW_OP), .SW_OP(SW_OP), .BEQ_OP(BEQ_OP),
    .MULT_FN(MULT_FN), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_opcode(ID_opcode), .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr),
    .EXE_opcode(EXE_opcode), .EXE_funct(EXE_funct), .EXE_rt_addr(EXE_rt_addr),
    .EXE_branch_taken(EXE_branch_taken),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EXE_bubble(ID_EXE_bubble), .EXE_hold(EXE_hold),
`ifdef STALL_STAT_EN
    .stall_cycles(stall_cycles),
`endif
    .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  // model state: win = cycles left in the current MULT window (0 = none), stat = stall count
  int         win;
  int         stat;
  int         n_checks;
  int         n_pass;
  logic [5:0] got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_in(input logic [5:0] id_op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [5:0] ex_op, input logic [5:0] ex_fn, input logic [4:0] ex_rt,
                        input logic br);
    ID_opcode = id_op; ID_rs_addr = rs; ID_rt_addr = rt;
    EXE_opcode = ex_op; EXE_funct = ex_fn; EXE_rt_addr = ex_rt;
    EXE_branch_taken = br;
  endtask

  // Entered just after a falling edge; compares mid-cycle, advances the model at the rising edge.
  task automatic tick(input string name);
    logic [5:0] e;
    logic       mul, ut, lu;
    int         w;
    #1;
    mul = (EXE_opcode == 6'h00) && (EXE_funct == MULT_FN);
    ut  = ID_opcode inside {6'h00, BEQ_OP, SW_OP};
    lu  = (EXE_opcode == LW_OP) && (EXE_rt_addr != 0) &&
          ((EXE_rt_addr == ID_rs_addr) || (ut && (EXE_rt_addr == ID_rt_addr)));
    w = win;
    if (w == 0 && mul) w = MUL_LAT;
    if (w >= 2)                e = {4'b0000, 1'b1, (w < MUL_LAT)};
    else if (EXE_branch_taken) e = 6'b111100;
    else if (lu)               e = 6'b000100;
    else                       e = 6'b110000;
    got = outs;
    check(name, got, e);
    check("invariant", {(ID_EXE_bubble && EXE_hold), (IF_ID_flush && !IF_ID_write)}, 2'b00);
`ifdef STALL_STAT_EN
    check("stall_cycles", stall_cycles, stat);
`endif
    @(posedge clk);
    win = (w > 0) ? w - 1 : 0;
    if (!e[5] && stat < (1 << STAT_W) - 1) stat++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    #1;
    win = 0; stat = 0;
    check("reset_outs", outs, 6'b110000);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_random();
    logic [5:0] ops [5];
    int r;
    ops = '{6'h00, LW_OP, SW_OP, BEQ_OP, 6'h08};
    ID_opcode  = ops[$urandom_range(0, 4)];
    ID_rs_addr = 5'($urandom_range(0, 3));
    ID_rt_addr = 5'($urandom_range(0, 3));
    EXE_branch_taken = ($urandom_range(0, 4) == 0);
    // a held or releasing MULT stays in EXE; otherwise a fresh instruction arrives
    if (win == 0) begin
      r = $urandom_range(0, 9);
      EXE_rt_addr = 5'($urandom_range(0, 3));
      if (r < 3) begin
        EXE_opcode = 6'h00; EXE_funct = MULT_FN;
      end else if (r < 6) begin
        EXE_opcode = LW_OP; EXE_funct = 6'($urandom_range(0, 63));
      end else begin
        EXE_opcode = ops[$urandom_range(0, 4)];
        EXE_funct  = ($urandom_range(0, 1) == 1) ? MULT_FN : 6'h20;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; win = 0; stat = 0;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    #3 check("reset_outs", outs, 6'b110000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // load-use: lw r5 in EXE, add using rs=5 in ID
    set_in(6'h00, 5, 1, LW_OP, 6'h00, 5, 1'b0);
    tick("load_use");       check("load_use_lit", got, 6'b000100);
    set_in(6'h00, 5, 1, 6'h00, 6'h20, 5, 1'b0);
    tick("after_lu");       check("after_lu_lit", got, 6'b110000);

    // no false stalls
    set_in(6'h00, 0, 0, LW_OP, 6'h00, 0, 1'b0);
    tick("lw_r0");          check("lw_r0_lit", got, 6'b110000);
    set_in(6'h08, 1, 7, LW_OP, 6'h00, 7, 1'b0);
    tick("addi_rt");        check("addi_rt_lit", got, 6'b110000);
    set_in(SW_OP, 1, 7, LW_OP, 6'h00, 7, 1'b0);
    tick("sw_rt");          check("sw_rt_lit", got, 6'b000100);

    // MULT: three hold cycles, busy in the 2nd and 3rd, release in the 4th
    set_in(6'h00, 0, 0, 6'h00, MULT_FN, 0, 1'b0);
    tick("mul_c1");         check("mul_c1_lit", got, 6'b000010);
    EXE_branch_taken = 1'b1;
    tick("mul_c2");         check("mul_c2_lit", got, 6'b000011);
    EXE_branch_taken = 1'b0;
    tick("mul_c3");         check("mul_c3_lit", got, 6'b000011);
    tick("mul_c4");         check("mul_c4_lit", got, 6'b110000);
    set_in(6'h00, 0, 0, 6'h00, 6'h00, 0, 1'b0);
    tick("mul_after");

    // taken branch beats load-use
    set_in(6'h00, 5, 1, LW_OP, 6'h00, 5, 1'b1);
    tick("br_vs_lu");       check("br_vs_lu_lit", got, 6'b111100);

    // reset in the 2nd MUL_BUSY cycle, then the still-present MULT restarts a full hold
    set_in(6'h00, 0, 0, 6'h00, MULT_FN, 0, 1'b0);
    tick("rb_c1");
    tick("rb_c2");
    #1 rst_n = 1'b0;
    #1 check("reset_busy", busy, 1'b0);
    check("reset_busy_outs", outs, 6'b000010);
    win = 0; stat = 0;
    #1 rst_n = 1'b1;
    tick("rb_r1");          check("rb_r1_lit", got, 6'b000010);
    tick("rb_r2");          check("rb_r2_lit", got, 6'b000011);
    tick("rb_r3");          check("rb_r3_lit", got, 6'b000011);
    tick("rb_r4");          check("rb_r4_lit", got, 6'b110000);

`ifdef STALL_STAT_EN
    do_reset();
    set_in(6'h00, 5, 1, LW_OP, 6'h00, 5, 1'b0);
    tick("st_lu");
    set_in(6'h00, 0, 0, 6'h00, MULT_FN, 0, 1'b0);
    for (int i = 0; i < MUL_LAT; i++) tick("st_mul");
    set_in(6'h00, 0, 0, 6'h00, 6'h00, 0, 1'b0);
    tick("st_idle");
    check("stall_total", stall_cycles, 16'd4);
    force dut.stall_q = 16'hFFFF;
    #1 release dut.stall_q;
    stat = 65535;
    set_in(6'h00, 5, 1, LW_OP, 6'h00, 5, 1'b0);
    tick("st_sat_lu");
    set_in(6'h00, 0, 0, 6'h00, 6'h00, 0, 1'b0);
    tick("st_sat_idle");
    check("stall_sat", stall_cycles, 16'hFFFF);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
